voice_phase_engine: RTL and testbench

Time-multiplexed, parametrised phase accumulator for the synth's polyphonic voice bank. It processes NUM_VOICES voices one per clock after each sample tick, using a runtime-writable per-voice increment table. It restarts a voice's phase on a gate rising edge and streams (voice, phase) pairs to the waveform lookup stage. It replaces the fixed-table, all-voices-every-clock accumulator, for larger voice counts and tunable pitch.

---
 rtl/voice_phase_engine.sv | 84 ++++++++
 tb/tb_voice_phase_engine.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/voice_phase_engine.sv
// voice_phase_engine: time-multiplexed per-voice phase accumulator, one voice per clock after each sample tick
// Ports: clk_in/rst_in (sync active-high); sample_tick_in starts a sweep; gate_in per-voice note-on level;
// inc_we_in/inc_addr_in/inc_data_in write the increment table; phase_out/voice_out/phase_valid_out/last_out
// stream one beat per voice; busy_out while sweeping; overrun_out pulses when a tick is dropped.
module voice_phase_engine #(
    parameter int NUM_VOICES  = 24,
    parameter int PHASE_WIDTH = 32,
    parameter int VIDX_WIDTH  = $clog2(NUM_VOICES)
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   sample_tick_in,
    input  logic [NUM_VOICES-1:0]  gate_in,
    input  logic                   inc_we_in,
    input  logic [VIDX_WIDTH-1:0]  inc_addr_in,
    input  logic [PHASE_WIDTH-1:0] inc_data_in,
    output logic [PHASE_WIDTH-1:0] phase_out,
    output logic [VIDX_WIDTH-1:0]  voice_out,
    output logic                   phase_valid_out,
    output logic                   last_out,
    output logic                   busy_out,
    output logic                   overrun_out
);
    localparam logic IDLE  = 1'b0;
    localparam logic SWEEP = 1'b1;
    logic                   state;
    logic [VIDX_WIDTH-1:0]  idx;
    logic [NUM_VOICES-1:0]  gate_prev;
    logic [NUM_VOICES-1:0]  gate_snap;
    logic [PHASE_WIDTH-1:0] inc   [NUM_VOICES];
    logic [PHASE_WIDTH-1:0] phase [NUM_VOICES];
    logic [PHASE_WIDTH-1:0] next_phase;
    logic                   last;
    logic                   wr_ok;
    // a voice restarts at zero while gated off and on the first sweep after its gate rises
    always_comb begin
        next_phase = (!gate_snap[idx] || !gate_prev[idx]) ? '0 : phase[idx] + inc[idx];
        last       = idx == VIDX_WIDTH'(NUM_VOICES - 1);
        wr_ok      = inc_we_in && (32'(inc_addr_in) < 32'(NUM_VOICES));
    end
    assign busy_out = state;
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= IDLE;
            idx             <= '0;
            gate_prev       <= '0;
            gate_snap       <= '0;
            phase_out       <= '0;
            voice_out       <= '0;
            phase_valid_out <= 1'b0;
            last_out        <= 1'b0;
            overrun_out     <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                inc[i]   <= '0;
                phase[i] <= '0;
            end
        end else begin
            phase_valid_out <= 1'b0;
            last_out        <= 1'b0;
            overrun_out     <= 1'b0;
            // the sweep reads inc[idx] before this edge, so a same-edge write lands for the next sweep
            if (wr_ok)
                inc[inc_addr_in] <= inc_data_in;
            if (state == IDLE) begin
                if (sample_tick_in) begin
                    gate_snap <= gate_in;
                    idx       <= '0;
                    state     <= SWEEP;
                end
            end else begin
                overrun_out     <= sample_tick_in;
                phase[idx]      <= next_phase;
                gate_prev[idx]  <= gate_snap[idx];
                phase_out       <= next_phase;
                voice_out       <= idx;
                phase_valid_out <= 1'b1;
                last_out        <= last;
                idx             <= idx + 1'b1;
                if (last)
                    state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_voice_phase_engine.sv
// tb_voice_phase_engine: randomized and directed checks of voice_phase_engine against a voice-level model
module tb_voice_phase_engine;
    localparam int N  = 24;
    localparam int PW = 32;
    localparam int VW = 5;
    logic          clk = 1'b0;
    logic          rst;
    logic          tick;
    logic [N-1:0]  gate;
    logic          we;
    logic [VW-1:0] addr;
    logic [PW-1:0] data;
    logic [PW-1:0] phase_o;
    logic [VW-1:0] voice_o;
    logic          valid_o;
    logic          last_o;
    logic          busy_o;
    logic          overrun_o;
    int            n_chk = 0;
    int            n_fail = 0;
    logic [PW-1:0] m_inc   [N];
    logic [PW-1:0] m_phase [N];
    bit            m_on    [N];
    logic [PW-1:0] obs     [N];

    voice_phase_engine #(.NUM_VOICES(N), .PHASE_WIDTH(PW)) dut (
        .clk_in(clk), .rst_in(rst), .sample_tick_in(tick), .gate_in(gate),
        .inc_we_in(we), .inc_addr_in(addr), .inc_data_in(data),
        .phase_out(phase_o), .voice_out(voice_o), .phase_valid_out(valid_o),
        .last_out(last_o), .busy_out(busy_o), .overrun_out(overrun_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_inc[i] = '0;
            m_phase[i] = '0;
            m_on[i] = 1'b0;
        end
    endtask

    task automatic model_write(input int a, input logic [PW-1:0] d);
        if (a < N)
            m_inc[a] = d;
    endtask

    task automatic write_inc(input int a, input logic [PW-1:0] d);
        we = 1'b1; addr = VW'(a); data = d;
        cyc();
        model_write(a, d);
        we = 1'b0;
        check("idle_valid", valid_o, 0);
    endtask

    task automatic idle(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            we = rnd && ($urandom_range(0, 2) == 0);
            addr = VW'($urandom_range(0, 31));
            data = $urandom;
            cyc();
            if (we) model_write(int'(addr), data);
            we = 1'b0;
            check("idle_valid", valid_o, 0);
            check("idle_busy", busy_o, 0);
        end
    endtask

    // One full sweep. A chained sweep's tick was already issued by the previous call.
    task automatic sweep(input logic [N-1:0] g, input bit chained, input bit chain_next,
                         input bit rnd, input int cv, input logic [PW-1:0] cdata);
        logic [PW-1:0] exp;
        bit tk;
        if (!chained) begin
            tick = 1'b1; gate = g;
            cyc();
            tick = 1'b0;
            check("start_busy", busy_o, 1);
            check("start_valid", valid_o, 0);
        end
        for (int k = 0; k < N; k++) begin
            tk = rnd && ($urandom_range(0, 5) == 0);
            if (k == cv) begin
                we = 1'b1; addr = VW'(k); data = cdata;
            end else begin
                we = rnd && ($urandom_range(0, 3) == 0);
                addr = VW'($urandom_range(0, 31));
                data = $urandom;
            end
            if (rnd) gate = N'($urandom);
            tick = tk;
            cyc();
            exp = (!g[k] || !m_on[k]) ? '0 : m_phase[k] + m_inc[k];
            m_phase[k] = exp;
            m_on[k] = g[k];
            if (we) model_write(int'(addr), data);
            we = 1'b0; tick = 1'b0;
            check("beat_valid", valid_o, 1);
            check("beat_voice", voice_o, k);
            check($sformatf("beat_phase_v%0d", k), phase_o, exp);
            check("beat_last", last_o, k == N - 1);
            check("beat_busy", busy_o, k != N - 1);
            check("beat_overrun", overrun_o, tk);
            obs[k] = phase_o;
        end
        gate = g;
        tick = chain_next;
        cyc();
        tick = 1'b0;
        check("end_valid", valid_o, 0);
        check("end_last", last_o, 0);
        check("end_overrun", overrun_o, 0);
        check("end_busy", busy_o, chain_next);
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; gate = '0; we = 1'b0; addr = '0; data = '0;
        model_reset();
        cyc(); cyc();
        check("rst_phase", phase_o, 0);
        check("rst_voice", voice_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_last", last_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_overrun", overrun_o, 0);
        rst = 1'b0;
        idle(2, 0);

        write_inc(5, 18898);
        sweep(N'(1) << 5, 0, 0, 0, -1, 0); check("acc5_0", obs[5], 0); idle(15, 0);
        sweep(N'(1) << 5, 0, 0, 0, -1, 0); check("acc5_1", obs[5], 18898); idle(15, 0);
        sweep(N'(1) << 5, 0, 0, 0, -1, 0); check("acc5_2", obs[5], 37796);
        check("acc_other", obs[4], 0);

        write_inc(0, 32'h8000_0000);
        sweep(N'(1), 0, 0, 0, -1, 0); check("wrap_0", obs[0], 0);
        sweep(N'(1), 0, 0, 0, -1, 0); check("wrap_1", obs[0], 32'h8000_0000);
        sweep(N'(1), 0, 0, 0, -1, 0); check("wrap_2", obs[0], 0);
        sweep(N'(1), 0, 0, 0, -1, 0); check("wrap_3", obs[0], 32'h8000_0000);

        write_inc(3, 100);
        sweep(N'(8), 0, 0, 0, -1, 0); check("gate_a0", obs[3], 0);
        sweep(N'(8), 0, 0, 0, -1, 0); check("gate_a1", obs[3], 100);
        sweep(N'(8), 0, 0, 0, -1, 0); check("gate_a2", obs[3], 200);
        sweep(N'(0), 0, 0, 0, -1, 0); check("gate_off", obs[3], 0);
        sweep(N'(8), 0, 0, 0, -1, 0); check("gate_b0", obs[3], 0);
        sweep(N'(8), 0, 0, 0, -1, 0); check("gate_b1", obs[3], 100);

        write_inc(2, 50);
        sweep(N'(4), 0, 0, 0, -1, 0); check("coll_0", obs[2], 0);
        sweep(N'(4), 0, 0, 0, 2, 7);  check("coll_old", obs[2], 50);
        sweep(N'(4), 0, 0, 0, -1, 0); check("coll_new", obs[2], 57);
        write_inc(30, 32'hdead_beef);
        sweep(N'(4), 0, 0, 0, -1, 0); check("bad_addr", obs[2], 64);

        sweep(N'(4), 0, 1, 0, -1, 0);
        sweep(N'(4), 1, 0, 0, -1, 0); check("chain_25", obs[2], 78);

        for (int s = 0; s < 30; s++) begin
            sweep(N'($urandom), 0, 0, 1, -1, 0);
            idle($urandom_range(0, 5), 1);
        end

        tick = 1'b1; gate = '1;
        cyc();
        tick = 1'b0;
        repeat (5) cyc();
        check("pre_rst_valid", valid_o, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        model_reset();
        check("mid_rst_phase", phase_o, 0);
        check("mid_rst_voice", voice_o, 0);
        check("mid_rst_valid", valid_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_last", last_o, 0);
        check("mid_rst_overrun", overrun_o, 0);
        idle(30, 0);
        sweep('1, 0, 0, 0, -1, 0); check("post_rst_v0", obs[0], 0);
        sweep('1, 0, 0, 0, -1, 0); check("post_rst_inc", obs[5], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
